// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_reset_pkg;

    localparam int LOSS_CNT_W = 8;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STAGGER   = 2'd1,
        RUN       = 2'd2
    } pll_rst_state_t;

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Lock input and reset/status outputs of the PLL reset sequencer.
// lock_loss_cnt_o exists only when PLL_RESET_LOSS_COUNT_EN is defined.
interface pll_reset_sequencer_if;
    import pll_reset_pkg::*;

    logic locked_i;
    logic rst_core_o;
    logic rst_periph_o;
    logic ready_o;
    logic lock_lost_o;
`ifdef PLL_RESET_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] lock_loss_cnt_o;
`endif

    modport master (
        input  locked_i,
        output rst_core_o, rst_periph_o, ready_o, lock_lost_o
`ifdef PLL_RESET_LOSS_COUNT_EN
        , output lock_loss_cnt_o
`endif
    );

    modport slave (
        output locked_i,
        input  rst_core_o, rst_periph_o, ready_o, lock_lost_o
`ifdef PLL_RESET_LOSS_COUNT_EN
        , input lock_loss_cnt_o
`endif
    );

endinterface

// File: rtl/pll_reset_sequencer_sync.sv
// Generic two-flop synchroniser with synchronous active-high reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Releases core then peripheral reset once PLL lock is filtered; re-asserts on lock loss.
// Optional saturating lock-loss counter under PLL_RESET_LOSS_COUNT_EN.
//
//   state     | meaning
//   WAIT_LOCK | both resets held, counting consecutive synchronised lock cycles
//   STAGGER   | core released, counting down to peripheral release
//   RUN       | both resets released, ready_o high
module pll_reset_sequencer #(
    parameter int LOCK_FILTER = 256,
    parameter int STAGGER     = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pll_reset_sequencer_if.master bus
);
    import pll_reset_pkg::*;

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);

    logic             w_lk_s;
    pll_rst_state_t   r_state;
    pll_rst_state_t   w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_lost;
    logic             w_rst_core_nxt;
    logic             w_rst_periph_nxt;
    logic             w_ready_nxt;
    logic             r_rst_core;
    logic             r_rst_periph;
    logic             r_ready;
    logic             r_lock_lost;

    sync_2ff #(.WIDTH(1)) u_sync (
        .i_clk (clk),
        .i_rst (reset),
        .i_d   (bus.locked_i),
        .o_q   (w_lk_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= WAIT_LOCK;
            r_cnt        <= '0;
            r_rst_core   <= 1'b1;
            r_rst_periph <= 1'b1;
            r_ready      <= 1'b0;
            r_lock_lost  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rst_core   <= w_rst_core_nxt;
            r_rst_periph <= w_rst_periph_nxt;
            r_ready      <= w_ready_nxt;
            r_lock_lost  <= w_lost;
        end
    end

    // A lock drop takes precedence over any count progress outside WAIT_LOCK.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lost      = 1'b0;
        case (r_state)
            WAIT_LOCK: begin
                if (!w_lk_s) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == FILT_LAST) begin
                    w_state_nxt = pll_reset_pkg::STAGGER;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            pll_reset_pkg::STAGGER: begin
                if (!w_lk_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_lost      = 1'b1;
                end else if (r_cnt == STAG_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!w_lk_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_lost      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_rst_core_nxt   = (w_state_nxt == WAIT_LOCK);
        w_rst_periph_nxt = (w_state_nxt != RUN);
        w_ready_nxt      = (w_state_nxt == RUN);
    end

    assign bus.rst_core_o   = r_rst_core;
    assign bus.rst_periph_o = r_rst_periph;
    assign bus.ready_o      = r_ready;
    assign bus.lock_lost_o  = r_lock_lost;

`ifdef PLL_RESET_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] r_loss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_loss_cnt <= '0;
        end else if (w_lost && (r_loss_cnt != '1)) begin
            r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
        end
    end

    assign bus.lock_loss_cnt_o = r_loss_cnt;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences reset release for the system clock domain from the main PLL's `locked` output. It synchronises and filters the asynchronous lock signal, then releases the core reset and, after a fixed stagger, the peripheral reset. Any later loss of lock re-asserts both resets and is reported as an event. The block sits directly downstream of the main PLL and is clocked by the PLL's 75 MHz primary output.

## Interface
Parameters:
- `LOCK_FILTER`, 256: consecutive synchronised-high `locked` cycles required before the core reset is released; minimum 1.
- `STAGGER`, 16: cycles between core reset release and peripheral reset release; minimum 1.
- `CNT_W`, 16: width of the internal cycle counter; must satisfy max(LOCK_FILTER, STAGGER) ≤ 2^CNT_W.

Ports:
- `clk` input 1: 75 MHz system clock (PLL primary output).
- `reset` input 1: synchronous, active-high; forces the initial state.
- `locked_i` input 1: PLL lock, asynchronous to `clk`.
- `rst_core_o` output 1: active-high reset for the CPU/bus core.
- `rst_periph_o` output 1: active-high reset for peripherals.
- `ready_o` output 1: high while in RUN.
- `lock_lost_o` output 1: one-cycle pulse on loss of lock after the filter has passed.
- `lock_loss_cnt_o` output 8: saturating lock-loss count (present only with the macro, see Configuration).

## Operation
- `locked_i` passes through a 2-flop synchroniser to produce `lk_s`; the reset value of both flops is 0.
- State machine WAIT_LOCK / STAGGER / RUN, with a single counter `cnt`.
- WAIT_LOCK:
  - `lk_s`=1: `cnt`++.
  - `lk_s`=0: `cnt`←0.
  - When `lk_s`=1 and `cnt`==LOCK_FILTER-1: go to STAGGER, `cnt`←0, `rst_core_o`←0.
- STAGGER:
  - `cnt`++ each cycle.
  - When `cnt`==STAGGER-1: go to RUN, `rst_periph_o`←0, `ready_o`←1.
- STAGGER or RUN with `lk_s`=0:
  - go to WAIT_LOCK, `cnt`←0;
  - `rst_core_o`, `rst_periph_o`←1, `ready_o`←0;
  - `lock_lost_o`=1 for exactly one cycle.
- A lock drop while in WAIT_LOCK only clears `cnt`; it does not generate an event.
- All outputs are registered; no output has a combinational path from inputs.

## Timing
- Reset values: `rst_core_o`=1, `rst_periph_o`=1, `ready_o`=0, `lock_lost_o`=0, `lock_loss_cnt_o`=0, state=WAIT_LOCK, `cnt`=0.
- Edge 1 is the first edge that samples `locked_i`=1, with lock held thereafter:
  - `rst_core_o` falls after edge LOCK_FILTER+2;
  - `rst_periph_o` falls and `ready_o` rises after edge LOCK_FILTER+STAGGER+2.
- Lock-loss response: `locked_i` low sampled at edge n → resets reasserted and `lock_lost_o` high after edge n+2.
- A `locked_i` glitch shorter than the filter window restarts the count from 0.
- `reset` has priority over everything. Asserting it mid-STAGGER or mid-RUN returns to reset values with no `lock_lost_o` pulse and no count increment.
- Lock loss and `reset` in the same cycle: `reset` wins.

## Configuration
- `PLL_RESET_LOSS_COUNT_EN` defined: `lock_loss_cnt_o` exists and increments on each `lock_lost_o` pulse, saturating at 255. It is cleared only by `reset`.
- Macro undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `pll_reset_pkg` holds:
  - the state enum `pll_rst_state_t` (WAIT_LOCK, STAGGER, RUN);
  - the constant `LOSS_CNT_W`=8.
- One sub-module, `sync_2ff`: a generic 2-flop synchroniser with synchronous reset, reused for other asynchronous inputs.

## Test plan
- LOCK_FILTER=8, STAGGER=4, `locked_i` held high from edge 1 → `rst_core_o` falls after edge 10, `rst_periph_o` falls and `ready_o` rises after edge 14.
- `locked_i` high 5 cycles, low 1 cycle, then high → no release until 8 consecutive synchronised highs; `lock_lost_o` stays 0.
- `locked_i` drops in RUN, sampled at edge 30 → both resets high and `lock_lost_o` pulsed after edge 32; `lock_loss_cnt_o`=1; full re-sequence on relock.
- `reset` asserted in STAGGER at `cnt`=2 → all outputs return to reset values next cycle; `lock_lost_o` stays 0; `lock_loss_cnt_o` stays 0.
- 260 lock-loss events with the macro defined → `lock_loss_cnt_o` saturates at 255.
- Lock loss and `reset` in the same cycle → no pulse, count unchanged.
